// File: rtl/uart_rx.sv
// 8-bit UART receiver: 2-flop synchronizer, mid-bit sampling FSM, valid/ready output with overrun.
// Optional even-parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_error,
  output logic       o_parity_error,
  output logic       o_overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q;
  logic          rx_meta_q, rx_s_q;
  logic          valid_q, ferr_q, ovr_q;
  logic          done_c, ferr_c, perr_c, par_bad;

`ifdef UART_RX_PARITY_EN
  logic bad_q, bad_d, perr_q;
  assign par_bad        = bad_q;
  assign o_parity_error = perr_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bad_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      bad_q  <= bad_d;
      perr_q <= perr_c;
    end
  end
`else
  assign par_bad        = 1'b0;
  assign o_parity_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_c  = 1'b0;
    ferr_c  = 1'b0;
    perr_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_d   = bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        bad_d = 1'b0;
`endif
        if (!rx_s_q) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        // Line back high at mid start bit: treat as a glitch
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shreg_d = {rx_s_q, shreg_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = STOP;
        if (^{shreg_q, rx_s_q}) begin
          perr_c = 1'b1;
          bad_d  = 1'b1;
        end
      end
`endif
      STOP: if (cnt_q == LAST) begin
        // A parity-failed frame never reports a framing error as well
        cnt_d = '0;
        if (rx_s_q) begin
          done_c  = !par_bad;
          state_d = IDLE;
        end else begin
          ferr_c  = !par_bad;
          state_d = BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      ferr_q    <= ferr_c;
      ovr_q     <= done_c && valid_q && !i_ready;
      if (done_c && (!valid_q || i_ready)) begin
        valid_q <= 1'b1;
        data_q  <= shreg_q;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;
  assign o_overrun     = ovr_q;
endmodule
